simon_round_engine: RTL and testbench

Simon 128/256 encryption datapath, directly downstream of the key-schedule generator. Captures the stream of 64-bit round keys into an internal key table. Then encrypts 128-bit blocks one round per clock, with valid/ready handshakes on both the block input and the block output. Round keys are loaded once and reused for every block until the next reload.

---
 rtl/simon_round_engine.sv | 199 +++++++++++++++++++
 tb/tb_simon_round_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_engine.sv
// simon_round_engine: Simon 128/256 block datapath with a 64-bit round-key table.
// Captures a stream of round keys, then runs one round per clock with valid/ready
// handshakes on the block input and output.
// Optional feature macro: SIMON_DECRYPT_EN adds the decrypt port and inverse rounds.
module simon_round_engine #(
  parameter int unsigned ROUNDS = 72
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         key_load,
  input  logic         rk_valid,
  input  logic [63:0]  rk,
  output logic         keys_ready,
  output logic         key_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
`ifdef SIMON_DECRYPT_EN
  input  logic         decrypt,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam int unsigned IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned WW = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;

  logic [WW-1:0]   key_tab [ROUNDS];
  logic [CW-1:0]   wr_idx_q;
  logic [CW-1:0]   wr_idx_d;
  logic [CW-1:0]   idx_base;
  logic            rdy_base;
  logic            key_we;
  logic            keys_ready_d;
  logic            key_err_d;
  logic            is_idle;
  logic            load_c;

  logic [WW-1:0]   x_q;
  logic [WW-1:0]   y_q;
  logic [WW-1:0]   x_nxt;
  logic [WW-1:0]   y_nxt;
  logic [WW-1:0]   rk_sel;
  logic [CW-1:0]   rnd_q;
  logic            last_round;
  logic            accept;
`ifdef SIMON_DECRYPT_EN
  logic            dec_q;
  logic [CW-1:0]   rev_idx;
`endif

  // Simon mixing function on one 64-bit half
  function automatic logic [WW-1:0] simon_f(input logic [WW-1:0] v);
    logic [WW-1:0] r1;
    logic [WW-1:0] r2;
    logic [WW-1:0] r8;
    r1 = {v[WW-2:0], v[WW-1]};
    r2 = {v[WW-3:0], v[WW-1:WW-2]};
    r8 = {v[WW-9:0], v[WW-1:WW-8]};
    return (r1 & r8) ^ r2;
  endfunction

  assign is_idle    = (state_q == S_IDLE);
  assign load_c     = key_load & is_idle;
  assign accept     = is_idle & keys_ready & in_valid;
  assign last_round = (rnd_q == CW'(ROUNDS - 1));

  // Key capture bookkeeping: load restarts the index, a same-cycle word lands as k0
  always_comb begin
    idx_base     = load_c ? '0 : wr_idx_q;
    rdy_base     = load_c ? 1'b0 : keys_ready;
    key_we       = rk_valid & is_idle & (idx_base < CW'(ROUNDS));
    wr_idx_d     = key_we ? (idx_base + CW'(1)) : idx_base;
    keys_ready_d = rdy_base | (key_we & (idx_base == CW'(ROUNDS - 1)));
    key_err_d    = load_c ? 1'b0 : key_err;
    if (rk_valid && !is_idle) begin
      key_err_d = 1'b1;
    end
  end

  // Key index, ready and sticky error registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_idx_q   <= '0;
      keys_ready <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      keys_ready <= keys_ready_d;
      key_err    <= key_err_d;
    end
  end

  // Round-key table; contents only meaningful once keys_ready is set
  always_ff @(posedge clk) begin
    if (key_we) begin
      key_tab[IW'(idx_base)] <= rk;
    end
  end

  // One Simon round on the current state, forward by default
  always_comb begin
    rk_sel = key_tab[IW'(rnd_q)];
    x_nxt  = y_q ^ simon_f(x_q) ^ rk_sel;
    y_nxt  = x_q;
`ifdef SIMON_DECRYPT_EN
    rev_idx = CW'(ROUNDS - 1) - rnd_q;
    if (dec_q) begin
      rk_sel = key_tab[IW'(rev_idx)];
      x_nxt  = y_q;
      y_nxt  = x_q ^ simon_f(y_q) ^ rk_sel;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_RUN;
      S_RUN:   if (last_round) state_d = S_HOLD;
      S_HOLD:  if (out_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = keys_ready;
      S_RUN:   busy = 1'b1;
      S_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Block state, round counter and result register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      x_q       <= '0;
      y_q       <= '0;
      rnd_q     <= '0;
      out_block <= '0;
`ifdef SIMON_DECRYPT_EN
      dec_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_q   <= in_block[127:64];
            y_q   <= in_block[63:0];
            rnd_q <= '0;
`ifdef SIMON_DECRYPT_EN
            dec_q <= decrypt;
`endif
          end
        end
        S_RUN: begin
          x_q   <= x_nxt;
          y_q   <= y_nxt;
          rnd_q <= rnd_q + CW'(1);
          if (last_round) begin
            out_block <= {x_nxt, y_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_engine.sv
// tb_simon_round_engine: randomized and known-answer bench for simon_round_engine.
// Honors SIMON_DECRYPT_EN to exercise the decrypt port.
`timescale 1ns/1ps
module tb_simon_round_engine;

  localparam int unsigned ROUNDS = 72;
`ifdef SIMON_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         key_load = 1'b0;
  logic         rk_valid = 1'b0;
  logic [63:0]  rk = '0;
  logic         keys_ready;
  logic         key_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic         decrypt = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] stage [ROUNDS];
  logic [63:0] mkey  [ROUNDS];

  localparam logic [127:0] KAT_PT = {64'h74206e69206d6f6f, 64'h6d69732061207369};
  localparam logic [127:0] KAT_CT = {64'h8d2b5579afc8a3a0, 64'h3bf72a87efe7b868};

  simon_round_engine #(.ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .res_n      (res_n),
    .key_load   (key_load),
    .rk_valid   (rk_valid),
    .rk         (rk),
    .keys_ready (keys_ready),
    .key_err    (key_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
`ifdef SIMON_DECRYPT_EN
    .decrypt    (decrypt),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] fmix(input logic [63:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Reference cipher over the keys the bench believes the DUT holds
  function automatic logic [127:0] model(input logic [127:0] blk, input logic dec);
    logic [63:0] x, y, t;
    x = blk[127:64];
    y = blk[63:0];
    for (int r = 0; r < ROUNDS; r++) begin
      if (!dec) begin
        t = x;
        x = y ^ fmix(x) ^ mkey[r];
        y = t;
      end else begin
        t = y;
        y = x ^ fmix(y) ^ mkey[ROUNDS - 1 - r];
        x = t;
      end
    end
    return {x, y};
  endfunction

  // Simon 128/256 key expansion into the staging table
  task automatic expand_keys(input logic [63:0] k0, input logic [63:0] k1,
                             input logic [63:0] k2, input logic [63:0] k3);
    logic [61:0] z;
    logic [63:0] tmp;
    z = 62'b11110111001001010011000011101000000100011011010110011110001011;
    stage[0] = k0;
    stage[1] = k1;
    stage[2] = k2;
    stage[3] = k3;
    for (int i = 0; i + 4 < ROUNDS; i++) begin
      tmp = ror(stage[i + 3], 3) ^ stage[i + 1];
      tmp = tmp ^ ror(tmp, 1);
      stage[i + 4] = ~stage[i] ^ tmp ^ 64'(z[i % 62]) ^ 64'd3;
    end
  endtask

  // Stream the staging table into the DUT; optional trailing words must be dropped
  task automatic load_keys(input bit combined, input int extra);
    key_load = 1'b1;
    if (combined) begin
      rk_valid = 1'b1;
      rk = stage[0];
    end
    @(negedge clk);
    key_load = 1'b0;
    for (int i = (combined ? 1 : 0); i < ROUNDS; i++) begin
      rk_valid = 1'b1;
      rk = stage[i];
      if (i == ROUNDS - 1) check_eq("keys_ready_before_last", 128'(keys_ready), 128'd0);
      @(negedge clk);
    end
    rk_valid = 1'b0;
    check_eq("keys_ready_after_last", 128'(keys_ready), 128'd1);
    for (int i = 0; i < extra; i++) begin
      rk_valid = 1'b1;
      rk = {$urandom, $urandom};
      @(negedge clk);
    end
    rk_valid = 1'b0;
    check_eq("key_err_idle_load", 128'(key_err), 128'd0);
    for (int i = 0; i < ROUNDS; i++) mkey[i] = stage[i];
  endtask

  // Push one block through, optionally disturbing the key port mid-run and stalling output
  task automatic run_block(input logic [127:0] blk, input logic dec, input int hold,
                           input int err_at, input string tag, output logic [127:0] got);
    int k;
    int guard;
    logic [127:0] exp;
    logic [127:0] held;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_block = blk;
    decrypt  = dec;
    exp      = model(blk, decrypt);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    decrypt  = DEC_EN & ~dec;
    check_eq({tag, "_run_status"}, 128'({busy, in_ready, out_valid}), 128'(3'b100));
    k = 0;
    while (!out_valid && k < 200) begin
      if (k == err_at) begin
        rk_valid = 1'b1;
        rk = '1;
        key_load = 1'b1;
      end
      @(negedge clk);
      k++;
      rk_valid = 1'b0;
      key_load = 1'b0;
    end
    check_eq({tag, "_latency"}, 128'(k), 128'(ROUNDS));
    check_eq({tag, "_result"}, out_block, exp);
    got = out_block;
    if (err_at >= 0) begin
      check_eq({tag, "_key_err"}, 128'({key_err, keys_ready}), 128'(2'b11));
    end
    held = out_block;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq({tag, "_hold_block"}, out_block, held);
      check_eq({tag, "_hold_status"}, 128'({out_valid, in_ready, busy}), 128'(3'b101));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_after_hs"}, 128'({in_ready, out_valid, busy}), 128'(3'b100));
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] blk;
    logic         dec;
    int           cnt;

    // Reset and idle behaviour with no keys
    repeat (3) @(negedge clk);
    check_eq("reset_flags", 128'({keys_ready, key_err, in_ready, out_valid, busy}), 128'd0);
    check_eq("reset_block", out_block, 128'd0);
    res_n = 1'b1;
    in_valid = 1'b1;
    in_block = KAT_PT;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_no_keys", 128'({in_ready, out_valid, busy, keys_ready}), 128'd0);
    end
    in_valid = 1'b0;

    // Known-answer encryption, back-to-back with a stalled second block
    expand_keys(64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
                64'h1716151413121110, 64'h1f1e1d1c1b1a1918);
    load_keys(1'b0, 3);
    run_block(KAT_PT, 1'b0, 0, -1, "kat", got);
    check_eq("kat_const", got, KAT_CT);
    run_block(KAT_PT, 1'b0, 10, -1, "kat_bp", got);
    check_eq("kat_bp_const", got, KAT_CT);

    // Key word and reload attempt during RUN must not disturb the block
    run_block(KAT_PT, 1'b0, 0, 20, "kat_err", got);
    check_eq("kat_err_const", got, KAT_CT);
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    check_eq("reload_clears", 128'({key_err, keys_ready}), 128'd0);
    load_keys(1'b1, 0);

`ifdef SIMON_DECRYPT_EN
    run_block(KAT_CT, 1'b1, 0, -1, "kat_dec", got);
    check_eq("kat_dec_const", got, KAT_PT);
`endif

    // Reset in the middle of a block
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_block = KAT_PT;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    res_n = 1'b0;
    #1;
    check_eq("midrun_reset_flags", 128'({busy, out_valid, keys_ready}), 128'd0);
    check_eq("midrun_reset_block", out_block, 128'd0);
    @(negedge clk);
    res_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check_eq("aborted_no_output", 128'(cnt), 128'd0);

    // Random key sets and blocks against the reference cipher
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < ROUNDS; i++) stage[i] = {$urandom, $urandom};
      load_keys(1'b1, int'($urandom_range(0, 3)));
      for (int b = 0; b < 6; b++) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        dec = DEC_EN & $urandom_range(0, 1);
        run_block(blk, dec, int'($urandom_range(0, 3)), -1, "rand", got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
